// File: rtl/ifetch_stage_if.sv
// ifetch_stage_if: instruction-memory request/response bundle.
// master = fetch stage, slave = instruction memory.
interface ifetch_stage_if;
  logic [15:0] imem_address;
  logic        imem_read;
  logic        imem_resp;
  logic [15:0] imem_rdata;

  modport master (
    output imem_address,
    output imem_read,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_address,
    input  imem_read,
    output imem_resp,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_stage.sv
// ifetch_stage: LC-3b fetch stage with PC, one-entry skid and branch hold/flush.
// Define IFETCH_BR_HOLD_EN to hold fetch after each control-flow instruction.
module ifetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_stage_if.master imem,
  input  logic           stall,
  input  logic           br_resolve,
  input  logic           br_taken,
  input  logic [15:0]    br_target,
  output logic           id_valid,
  output logic [15:0]    id_ir,
  output logic [15:0]    id_pc,
  output logic [3:0]     id_opcode,
  output logic           id_imm_check,
  output logic           id_jsr_check,
  output logic           id_rshf_check
);

`ifdef IFETCH_BR_HOLD_EN
  localparam bit BR_HOLD = 1'b1;
`else
  localparam bit BR_HOLD = 1'b0;
`endif

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    WAIT_BR,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drop_addr_q, drop_addr_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] id_ir_q, id_ir_d;
  logic [15:0] id_pc_q, id_pc_d;
  logic        sk_valid_q, sk_valid_d;
  logic [15:0] sk_ir_q, sk_ir_d;
  logic [15:0] sk_pc_q, sk_pc_d;

  logic        rd;
  logic        cap;
  logic        slot_free;
  logic [15:0] pc_inc;
  logic [15:0] addr;

  function automatic logic is_cf(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    is_cf = 1'b0;
    unique case (1'b1)
      (op == OP_BR),
      (op == OP_JMP),
      (op == OP_JSR),
      (op == OP_TRAP): is_cf = 1'b1;
      default:         is_cf = 1'b0;
    endcase
  endfunction

  // Reset forces the request low so a late response is never taken.
  assign rd        = ~reset & ((state_q == FETCH) | (state_q == DROP));
  assign addr      = (state_q == DROP) ? drop_addr_q : pc_q;
  assign cap       = rd & imem.imem_resp;
  assign slot_free = ~id_valid_q | ~stall;
  assign pc_inc    = pc_q + 16'd2;

  assign imem.imem_read    = rd;
  assign imem.imem_address = addr;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    id_valid_d  = id_valid_q;
    id_ir_d     = id_ir_q;
    id_pc_d     = id_pc_q;
    sk_valid_d  = sk_valid_q;
    sk_ir_d     = sk_ir_q;
    sk_pc_d     = sk_pc_q;

    if (id_valid_q & ~stall) id_valid_d = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (cap) begin
          pc_d = pc_inc;
          if (slot_free) begin
            id_valid_d = 1'b1;
            id_ir_d    = imem.imem_rdata;
            id_pc_d    = pc_inc;
            if (BR_HOLD && is_cf(imem.imem_rdata)) state_d = WAIT_BR;
          end else begin
            sk_valid_d = 1'b1;
            sk_ir_d    = imem.imem_rdata;
            sk_pc_d    = pc_inc;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (~stall) begin
          id_valid_d = 1'b1;
          id_ir_d    = sk_ir_q;
          id_pc_d    = sk_pc_q;
          sk_valid_d = 1'b0;
          state_d    = (BR_HOLD && is_cf(sk_ir_q)) ? WAIT_BR : FETCH;
        end
      end
      WAIT_BR: begin
        if (br_resolve) begin
          if (br_taken) pc_d = br_target;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (cap) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

`ifndef IFETCH_BR_HOLD_EN
    // Taken redirect flushes both slots; an unanswered read must still drain.
    if (br_resolve & br_taken) begin
      id_valid_d = 1'b0;
      sk_valid_d = 1'b0;
      pc_d       = br_target;
      if (rd & ~imem.imem_resp) begin
        state_d     = DROP;
        drop_addr_d = addr;
      end else begin
        state_d = FETCH;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= 16'h0000;
      id_valid_q  <= 1'b0;
      id_ir_q     <= 16'h0000;
      id_pc_q     <= 16'h0000;
      sk_valid_q  <= 1'b0;
      sk_ir_q     <= 16'h0000;
      sk_pc_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      id_valid_q  <= id_valid_d;
      id_ir_q     <= id_ir_d;
      id_pc_q     <= id_pc_d;
      sk_valid_q  <= sk_valid_d;
      sk_ir_q     <= sk_ir_d;
      sk_pc_q     <= sk_pc_d;
    end
  end

  assign id_valid      = id_valid_q;
  assign id_ir         = id_ir_q;
  assign id_pc         = id_pc_q;
  assign id_opcode     = id_ir_q[15:12];
  assign id_imm_check  = id_ir_q[5];
  assign id_jsr_check  = id_ir_q[11];
  assign id_rshf_check = id_ir_q[4];

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: randomized scoreboard bench for the LC-3b fetch stage.
// The model tracks the expected instruction stream from fetch/redirect rules.
`timescale 1ns/1ps
module tb_ifetch_stage;
  localparam logic [15:0] RST_PC = 16'h0100;
`ifdef IFETCH_BR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_resolve = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        id_valid;
  logic [15:0] id_ir, id_pc;
  logic [3:0]  id_opcode;
  logic        id_imm_check, id_jsr_check, id_rshf_check;

  ifetch_stage_if bus();

  ifetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (bus),
    .stall         (stall),
    .br_resolve    (br_resolve),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .id_valid      (id_valid),
    .id_ir         (id_ir),
    .id_pc         (id_pc),
    .id_opcode     (id_opcode),
    .id_imm_check  (id_imm_check),
    .id_jsr_check  (id_jsr_check),
    .id_rshf_check (id_rshf_check)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] mem [0:255];
  logic [15:0] mpc = RST_PC;
  logic [15:0] drop_addr = 16'h0000;
  logic [15:0] prev_addr = 16'h0000;
  bit          drop_pend = 1'b0;
  bit          prev_pend = 1'b0;
  bit          mwait = 1'b0;
  bit          mem_en = 1'b1;
  bit          lat_rand = 1'b0;
  int          lat = 0;
  int          wcnt = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  function automatic bit is_cf(input logic [15:0] w);
    return w[15:12] inside {4'h0, 4'h4, 4'hC, 4'hF};
  endfunction

  function automatic logic [15:0] memw(input logic [15:0] a);
    if (a == 16'h0106) return 16'h0000;
    if (a == 16'h0200) return 16'h0E05;
    if (a == 16'h0304) return 16'hF025;
    if (a == 16'h0010) return 16'h4ABC;
    return mem[a[8:1]];
  endfunction

  // One clock of memory + control stimulus, with the model updated alongside.
  task automatic tick(input bit st, input bit res, input bit tk,
                      input logic [15:0] tgt);
    logic [15:0] w;
    logic [15:0] npc;
    bit rsp;
    bit flush;
    rsp   = 1'b0;
    w     = 16'($urandom);
    flush = res && tk && !HOLD_EN;
    if (prev_pend && bus.imem_read)
      chk("addr_stable", bus.imem_address, prev_addr);
    if (mwait) chk("no_read_wait_br", bus.imem_read, 0);
    if (bus.imem_read && mem_en) begin
      if (wcnt >= lat) begin
        rsp  = 1'b1;
        wcnt = 0;
        w    = memw(bus.imem_address);
        if (drop_pend) begin
          chk("drop_addr", bus.imem_address, drop_addr);
          drop_pend = 1'b0;
        end else if (!flush) begin
          chk("fetch_addr", bus.imem_address, mpc);
          npc = mpc + 16'd2;
          exp_q.push_back('{w, npc});
          if (HOLD_EN && is_cf(w)) mwait = 1'b1;
          mpc = npc;
        end
        if (lat_rand) lat = $urandom_range(0, 3);
      end else begin
        wcnt++;
      end
    end else if (!bus.imem_read) begin
      wcnt = 0;
    end
    prev_pend = bus.imem_read && !rsp;
    prev_addr = bus.imem_address;
    bus.imem_resp  = rsp | (!bus.imem_read && $urandom_range(0, 3) == 0);
    bus.imem_rdata = w;
    stall      = st;
    br_resolve = res;
    br_taken   = tk;
    br_target  = tgt;
    if (flush) begin
      if (bus.imem_read && !rsp) begin
        drop_pend = 1'b1;
        drop_addr = bus.imem_address;
      end
      mpc = tgt;
    end
    if (HOLD_EN && res && mwait) begin
      if (tk) mpc = tgt;
      mwait = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.imem_resp = 1'b0;
    br_resolve    = 1'b0;
    if (flush) begin
      exp_q.delete();
      chk("flush_id_valid", id_valid, 0);
    end
  endtask

  task automatic do_reset(input bit late);
    reset         = 1'b1;
    stall         = 1'b0;
    br_resolve    = 1'b0;
    bus.imem_resp = late;
    bus.imem_rdata = 16'h1234;
    #1;
    chk("read_in_reset", bus.imem_read, 0);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.imem_resp = 1'b0;
    mpc = RST_PC;
    exp_q.delete();
    wcnt = 0;
    drop_pend = 1'b0;
    prev_pend = 1'b0;
    mwait = 1'b0;
    #1;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_ir", id_ir, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_read", bus.imem_read, 1);
    chk("rst_addr", bus.imem_address, RST_PC);
  endtask

  task automatic run_to_wait();
    int n;
    n = 0;
    while (!mwait && n < 20) begin
      tick(0, 0, 0, 16'h0000);
      n++;
    end
    chk("reach_wait_br", mwait, 1);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && id_valid && !stall) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL id_extra: got pc %0h ir %0h expected none", id_pc, id_ir);
      end else begin
        e = exp_q.pop_front();
        chk("id_ir", id_ir, e.ir);
        chk("id_pc", id_pc, e.pc);
        chk("id_opcode", id_opcode, e.ir[15:12]);
        chk("id_imm_check", id_imm_check, e.ir[5]);
        chk("id_jsr_check", id_jsr_check, e.ir[11]);
        chk("id_rshf_check", id_rshf_check, e.ir[4]);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  nocf [12];
    logic [15:0] tgt;
    int n;
    bit f, r;
    nocf = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
             4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
    for (int i = 0; i < 256; i++)
      mem[i] = {nocf[$urandom_range(0, 11)], 12'($urandom)};
    mem[8'h80] = {4'h1, 12'($urandom)};
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = 16'h0000;

    do_reset(1'b0);
    tick(0, 0, 0, 16'h0000);
    chk("first_id_valid", id_valid, 1);
    chk("first_id_pc", id_pc, 16'h0102);
    chk("first_opcode", id_opcode, 4'h1);
    tick(0, 0, 0, 16'h0000);
    tick(0, 0, 0, 16'h0000);

`ifdef IFETCH_BR_HOLD_EN
    run_to_wait();
    repeat (2) tick(0, 0, 0, 16'h0000);
    tick(0, 1, 1, 16'h0200);
    run_to_wait();
    repeat (2) tick(0, 0, 0, 16'h0000);
    tick(0, 1, 1, 16'h0300);
    tick(0, 1, 1, 16'h4000);
    run_to_wait();
    tick(0, 1, 1, 16'h0010);
    run_to_wait();
    chk("jsr_check", id_jsr_check, 1);
    tick(0, 1, 0, 16'h7770);
    repeat (3) tick(0, 0, 0, 16'h0000);
`else
    repeat (3) begin
      tick(1, 0, 0, 16'h0000);
      chk("skid_hold_read", bus.imem_read, 0);
    end
    repeat (4) tick(0, 0, 0, 16'h0000);

    lat_rand = 1'b1;
    repeat (400) begin
      f   = ($urandom_range(0, 99) < 4);
      r   = f | ($urandom_range(0, 99) < 3);
      tgt = 16'($urandom) & 16'hFFFE;
      tick($urandom_range(0, 99) < 30, r, f, tgt);
    end
    lat_rand = 1'b0;

    lat = 3;
    n = 0;
    while (!(bus.imem_read && wcnt == 1) && n < 50) begin
      tick(0, 0, 0, 16'h0000);
      n++;
    end
    tick(0, 1, 1, 16'h0400);
    chk("drop_read", bus.imem_read, 1);
    chk("drop_old_addr", bus.imem_address, drop_addr);
    repeat (12) tick(0, 0, 0, 16'h0000);

    lat = 0;
    tick(0, 1, 1, 16'hFFFC);
    repeat (5) tick(0, 0, 0, 16'h0000);
`endif

    lat = 3;
    n = 0;
    while (!(bus.imem_read && wcnt == 1) && n < 50) begin
      tick(0, 0, 0, 16'h0000);
      n++;
    end
    do_reset(1'b1);
    lat = 0;
    repeat (6) tick(0, 0, 0, 16'h0000);

    mem_en = 1'b0;
    repeat (4) tick(0, 0, 0, 16'h0000);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Fetch stage of the pipelined LC-3b datapath. It owns the PC, issues instruction reads to the instruction memory port, and presents one fetched instruction per cycle to the decode stage. Decode receives the PC and the pre-sliced fields the decode ROM consumes: opcode, bit 5, bit 11 and bit 4. The stage absorbs decode stalls with a one-entry skid register. It holds or flushes around control-flow instructions until the downstream stage resolves them.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- imem_address  out  16  fetch address (lc3b_word); equals PC.
- imem_read  out  1  read request; held until imem_resp.
- imem_resp  in  1  read complete; ignored while imem_read=0.
- imem_rdata  in  16  instruction word, valid with imem_resp.
- stall  in  1  decode cannot accept; id_* must hold.
- br_resolve  in  1  one-cycle pulse: outstanding control-flow instruction resolved.
- br_taken  in  1  with br_resolve: redirect to br_target.
- br_target  in  16  redirect PC.
- id_valid  out  1  id_* holds a live instruction.
- id_ir  out  16  instruction word.
- id_pc  out  16  address of the instruction + 2.
- id_opcode  out  4  id_ir[15:12] (lc3b_opcode).
- id_imm_check  out  1  id_ir[5].
- id_jsr_check  out  1  id_ir[11].
- id_rshf_check  out  1  id_ir[4].

## Operation
- State: pc (16), id slot (valid/ir/pc), skid slot (valid/ir/pc), FSM in {FETCH, HOLD, WAIT_BR, DROP}.
- Control-flow opcodes are op_br, op_jmp, op_jsr and op_trap. BR with nzp=000 is included.
- FETCH:
  - imem_read=1, imem_address=pc.
  - On imem_resp, the word goes to the id slot if the slot is free (id_valid=0 or stall=0). Otherwise it goes to the skid slot and the FSM moves to HOLD.
  - On capture, pc<=pc+2 and the captured pc field = pc+2 (16-bit wrap: 16'hFFFE -> 16'h0000).
  - If the captured opcode is control-flow, go to WAIT_BR (with IFETCH_BR_HOLD_EN).
- HOLD: imem_read=0. When stall=0, the id slot consumes and the skid moves into the id slot in the same edge. The next state is WAIT_BR if the skid word was control-flow, else FETCH.
- WAIT_BR: imem_read=0; id slot drains normally.
  - On br_resolve: pc<=br_taken ? br_target : pc, then go to FETCH.
  - br_resolve in any other state is ignored (with macro).
- id slot drain: when id_valid=1 and stall=0 and nothing new is captured, id_valid<=0.
- The id_* fields hold their values while stall=1. The decode field outputs are combinational slices of id_ir.

## Timing
- Reset values: pc=RESET_PC, state FETCH, id_valid=0, id_ir=0, id_pc=0, skid invalid, imem_read=0 in the reset cycle.
- imem_read=1 in the first cycle after reset deasserts.
- Latency: id_valid rises the cycle after imem_resp.
- With a memory that responds every cycle, throughput is one instruction per cycle. imem_address advances the cycle after each response.
- imem_address is stable while imem_read=1 and imem_resp=0.
- Reset mid-request: request abandoned; a late imem_resp is ignored because imem_read=0.
- A redirect takes effect on imem_address the cycle after br_resolve.

## Configuration
- IFETCH_BR_HOLD_EN defined: fetch stops after each control-flow instruction and waits for br_resolve, as above. br_taken=0 resumes at pc+2.
- Not defined: WAIT_BR is unused and fetch continues sequentially. Not-taken resolution has no effect. br_resolve with br_taken=1 is a flush:
  - id_valid and the skid are cleared in the same edge, and pc<=br_target.
  - If a request is outstanding and unanswered, the FSM enters DROP. DROP keeps imem_read=1 on the old address until imem_resp, discards that word, then goes to FETCH.
  - If imem_resp coincides with the flush, that word is discarded.

## Test plan
- Reset with RESET_PC=16'h0100 and a zero-wait memory returning ADD words -> imem_address 0100, 0102, 0104 on consecutive cycles. id_pc=0102 one cycle after the first resp, and id_opcode=op_add.
- Hold stall=1 for 3 cycles while the memory responds -> the first word is held in id, the second in skid, and imem_read=0. After stall falls, both words appear in order with no loss or duplication.
- Macro on; fetch BR at 0x0200, then br_resolve with br_taken=1, br_target=0x0300 -> no reads during WAIT_BR. The next imem_address is 0x0300.
- Macro on; JSR at 0x0010 resolved not-taken -> fetch resumes at 0x0012. id_jsr_check equals ir[11].
- Macro off; taken flush while a 3-cycle-latency read is pending -> the pending word is dropped, id_valid=0 after the flush edge, and the next address is br_target.
- Assert reset during a pending read with a late imem_resp -> the response is ignored, id_valid stays 0, and the first post-reset address is RESET_PC.
